// File: rtl/branch_predict_resolve.sv
// Direct-mapped 2-bit-counter BTB with combinational IF lookup, EX-stage training,
// and a registered one-cycle redirect/flush on mispredict.
module branch_predict_resolve #(
    parameter int IDX_BITS = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] if_pc,
    output logic        if_pred_taken,
    output logic [31:0] if_pred_target,
    input  logic        ex_valid,
    input  logic        ex_is_branch,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_target,
    input  logic        ex_branch_flag,
    input  logic        ex_pred_taken,
    input  logic [31:0] ex_pred_target,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        flush,
    output logic [31:0] mispredict_count
);
    localparam int ENTRIES  = 1 << IDX_BITS;
    localparam int TAG_BITS = 32 - IDX_BITS - 2;

    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

    logic                valid_q  [ENTRIES];
    logic [1:0]          ctr_q    [ENTRIES];
    logic [TAG_BITS-1:0] tag_q    [ENTRIES];
    logic [31:0]         target_q [ENTRIES];

    logic                redirect_valid_q;
    logic [31:0]         redirect_pc_q;
    logic [31:0]         redirect_pc_d;
    logic [31:0]         count_q;

    logic [IDX_BITS-1:0] if_idx;
    logic [TAG_BITS-1:0] if_tag;
    logic                if_hit;
    logic [IDX_BITS-1:0] ex_idx;
    logic [TAG_BITS-1:0] ex_tag;
    logic                ex_hit;
    logic                upd;
    logic                mp;
    logic                alloc;
    logic [1:0]          ctr_d;

    // Reads see the pre-edge table, so a same-cycle update is visible next cycle.
    assign if_idx         = if_pc[IDX_BITS+1:2];
    assign if_tag         = if_pc[31:IDX_BITS+2];
    assign if_hit         = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    assign if_pred_taken  = if_hit && ctr_q[if_idx][1];
    assign if_pred_target = if_pred_taken ? target_q[if_idx] : if_pc + 32'd4;

    assign ex_idx = ex_pc[IDX_BITS+1:2];
    assign ex_tag = ex_pc[31:IDX_BITS+2];
    assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

    // The instruction in EX during a redirect cycle is wrong-path and must be ignored.
    assign upd = ex_valid && ex_is_branch && !redirect_valid_q;
    assign mp  = upd && ((ex_branch_flag != ex_pred_taken) ||
                         (ex_branch_flag && (ex_pred_target != ex_target)));

    assign redirect_pc_d = ex_branch_flag ? ex_target : ex_pc + 32'd4;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        ctr_d = ctr_q[ex_idx];
        alloc = 1'b0;
        if (ex_hit) begin
            if (ex_branch_flag && ctr_q[ex_idx] != CTR_ST) begin
                ctr_d = ctr_q[ex_idx] + 2'd1;
            end else if (!ex_branch_flag && ctr_q[ex_idx] != CTR_SNT) begin
                ctr_d = ctr_q[ex_idx] - 2'd1;
            end
        end else if (ex_branch_flag) begin
            ctr_d = CTR_WT;
            alloc = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (rst) begin
            // NOTE: only valid and ctr carry reset; tag/target are don't-care while invalid and stay reset-free.
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= CTR_WNT;
            end
        end else if (upd && (ex_hit || ex_branch_flag)) begin
            valid_q[ex_idx] <= 1'b1;
            ctr_q[ex_idx]   <= ctr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && upd && ex_branch_flag) begin
            target_q[ex_idx] <= ex_target;
            if (alloc) begin
                tag_q[ex_idx] <= ex_tag;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= 32'd0;
            count_q          <= 32'd0;
        end else begin
            redirect_valid_q <= mp;
            if (mp) begin
                redirect_pc_q <= redirect_pc_d;
            end
            count_q <= count_q + {31'd0, mp};
        end
    end

    assign redirect_valid   = redirect_valid_q;
    assign flush            = redirect_valid_q;
    assign redirect_pc      = redirect_pc_q;
    assign mispredict_count = count_q;
endmodule

// File: tb/tb_branch_predict_resolve.sv
// Bench for branch_predict_resolve: directed scenarios plus randomized traffic
// against a table-of-entries reference model.
module tb_branch_predict_resolve;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] if_pc;
    logic        if_pred_taken;
    logic [31:0] if_pred_target;
    logic        ex_valid;
    logic        ex_is_branch;
    logic [31:0] ex_pc;
    logic [31:0] ex_target;
    logic        ex_branch_flag;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        flush;
    logic [31:0] mispredict_count;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: one record per table slot, counter as a plain 0..3 integer.
    bit          m_valid  [64];
    int unsigned m_tag    [64];
    logic [31:0] m_target [64];
    int          m_ctr    [64];
    bit          m_rv;
    logic [31:0] m_rpc;
    int unsigned m_cnt;

    always #5 clk = ~clk;

    branch_predict_resolve #(.IDX_BITS(6)) dut (
        .clk(clk), .rst(rst), .if_pc(if_pc),
        .if_pred_taken(if_pred_taken), .if_pred_target(if_pred_target),
        .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_pc(ex_pc),
        .ex_target(ex_target), .ex_branch_flag(ex_branch_flag),
        .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .flush(flush), .mispredict_count(mispredict_count)
    );

    function automatic int slot(input logic [31:0] pc);
        return int'((pc >> 2) % 64);
    endfunction

    function automatic void model_lookup(input logic [31:0] pc, output bit taken,
                                         output logic [31:0] tgt);
        int i;
        bit hit;
        i     = slot(pc);
        hit   = m_valid[i] && (m_tag[i] == (pc >> 8));
        taken = hit && (m_ctr[i] >= 2);
        tgt   = taken ? m_target[i] : pc + 32'd4;
    endfunction

    function automatic void model_step();
        int i;
        bit hit, upd, mp;
        if (rst) begin
            for (int k = 0; k < 64; k++) begin
                m_valid[k] = 1'b0;
                m_ctr[k]   = 1;
            end
            m_rv  = 1'b0;
            m_rpc = 32'd0;
            m_cnt = 0;
            return;
        end
        i   = slot(ex_pc);
        hit = m_valid[i] && (m_tag[i] == (ex_pc >> 8));
        upd = ex_valid && ex_is_branch && !m_rv;
        mp  = upd && ((ex_branch_flag != ex_pred_taken) ||
                      (ex_branch_flag && ex_pred_target != ex_target));
        if (upd) begin
            if (hit) begin
                if (ex_branch_flag) begin
                    m_ctr[i]    = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
                    m_target[i] = ex_target;
                end else begin
                    m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
                end
            end else if (ex_branch_flag) begin
                m_valid[i]  = 1'b1;
                m_tag[i]    = ex_pc >> 8;
                m_target[i] = ex_target;
                m_ctr[i]    = 2;
            end
        end
        m_rv = mp;
        if (mp) begin
            m_rpc = ex_branch_flag ? ex_target : ex_pc + 32'd4;
            m_cnt++;
        end
    endfunction

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ex_valid       = 1'b0;
        ex_is_branch   = 1'b0;
        ex_pc          = 32'd0;
        ex_target      = 32'd0;
        ex_branch_flag = 1'b0;
        ex_pred_taken  = 1'b0;
        ex_pred_target = 32'd0;
    endtask

    task automatic drive_branch(input logic [31:0] pc, input logic [31:0] tgt, input bit flag,
                                input bit pt, input logic [31:0] ptgt);
        ex_valid       = 1'b1;
        ex_is_branch   = 1'b1;
        ex_pc          = pc;
        ex_target      = tgt;
        ex_branch_flag = flag;
        ex_pred_taken  = pt;
        ex_pred_target = ptgt;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        if_pc = 32'h100;
        tick();
        tick();
        rst = 1'b0;
        #1;
        n_tests++; if (if_pred_taken !== 1'b0) begin n_fail++; $display("FAIL reset_pred_taken: got %0h want 0", if_pred_taken); end
        n_tests++; if (if_pred_target !== 32'h104) begin n_fail++; $display("FAIL reset_pred_target: got %0h want 104", if_pred_target); end
        n_tests++; if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL reset_redirect_valid: got %0h want 0", redirect_valid); end
        n_tests++; if (flush !== 1'b0) begin n_fail++; $display("FAIL reset_flush: got %0h want 0", flush); end
        n_tests++; if (redirect_pc !== 32'h0) begin n_fail++; $display("FAIL reset_redirect_pc: got %0h want 0", redirect_pc); end
        n_tests++; if (mispredict_count !== 32'h0) begin n_fail++; $display("FAIL reset_count: got %0h want 0", mispredict_count); end
    endtask

    task automatic test_cold_taken();
        drive_branch(32'h100, 32'h80, 1'b1, 1'b0, 32'h104);
        tick();
        idle();
        n_tests++; if (redirect_valid !== 1'b1) begin n_fail++; $display("FAIL cold_redirect_valid: got %0h want 1", redirect_valid); end
        n_tests++; if (flush !== 1'b1) begin n_fail++; $display("FAIL cold_flush: got %0h want 1", flush); end
        n_tests++; if (redirect_pc !== 32'h80) begin n_fail++; $display("FAIL cold_redirect_pc: got %0h want 80", redirect_pc); end
        n_tests++; if (mispredict_count !== 32'd1) begin n_fail++; $display("FAIL cold_count: got %0h want 1", mispredict_count); end
        tick();
        if_pc = 32'h100;
        #1;
        n_tests++; if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL cold_pulse_width: got %0h want 0", redirect_valid); end
        n_tests++; if (if_pred_taken !== 1'b1) begin n_fail++; $display("FAIL cold_lookup_taken: got %0h want 1", if_pred_taken); end
        n_tests++; if (if_pred_target !== 32'h80) begin n_fail++; $display("FAIL cold_lookup_target: got %0h want 80", if_pred_target); end
    endtask

    task automatic test_correct_pred();
        bit          pt;
        logic [31:0] ptg;
        drive_branch(32'h100, 32'h80, 1'b1, 1'b1, 32'h80);
        tick();
        idle();
        n_tests++; if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL correct_no_redirect: got %0h want 0", redirect_valid); end
        n_tests++; if (mispredict_count !== 32'd1) begin n_fail++; $display("FAIL correct_count: got %0h want 1", mispredict_count); end
        tick();
        // Three not-taken resolutions walk the counter 11 -> 10 -> 01 -> 00.
        for (int k = 0; k < 3; k++) begin
            model_lookup(32'h100, pt, ptg);
            drive_branch(32'h100, 32'h80, 1'b0, pt, ptg);
            tick();
            idle();
            n_tests++; if (redirect_valid !== (k != 2)) begin n_fail++; $display("FAIL nt%0d_redirect: got %0h want %0h", k, redirect_valid, (k != 2)); end
            if (k == 1) begin
                n_tests++; if (redirect_pc !== 32'h104) begin n_fail++; $display("FAIL nt1_redirect_pc: got %0h want 104", redirect_pc); end
            end
            tick();
            if_pc = 32'h100;
            #1;
            n_tests++; if (if_pred_taken !== (k == 0)) begin n_fail++; $display("FAIL nt%0d_lookup_taken: got %0h want %0h", k, if_pred_taken, (k == 0)); end
        end
        n_tests++; if (mispredict_count !== 32'd3) begin n_fail++; $display("FAIL nt_count: got %0h want 3", mispredict_count); end
    endtask

    task automatic test_target_mismatch();
        drive_branch(32'h100, 32'h200, 1'b1, 1'b1, 32'h80);
        tick();
        idle();
        n_tests++; if (redirect_valid !== 1'b1) begin n_fail++; $display("FAIL tgt_redirect_valid: got %0h want 1", redirect_valid); end
        n_tests++; if (redirect_pc !== 32'h200) begin n_fail++; $display("FAIL tgt_redirect_pc: got %0h want 200", redirect_pc); end
        tick();
        // Counter is now weak-NT; one more taken makes the new target visible.
        drive_branch(32'h100, 32'h200, 1'b1, 1'b0, 32'h104);
        tick();
        idle();
        tick();
        if_pc = 32'h100;
        #1;
        n_tests++; if (if_pred_taken !== 1'b1) begin n_fail++; $display("FAIL tgt_lookup_taken: got %0h want 1", if_pred_taken); end
        n_tests++; if (if_pred_target !== 32'h200) begin n_fail++; $display("FAIL tgt_lookup_target: got %0h want 200", if_pred_target); end
        n_tests++; if (mispredict_count !== 32'd5) begin n_fail++; $display("FAIL tgt_count: got %0h want 5", mispredict_count); end
    endtask

    task automatic test_wrong_path();
        drive_branch(32'h300, 32'h340, 1'b1, 1'b0, 32'h304);
        tick();
        drive_branch(32'h400, 32'h480, 1'b1, 1'b0, 32'h404);
        n_tests++; if (redirect_valid !== 1'b1) begin n_fail++; $display("FAIL wp_first_redirect: got %0h want 1", redirect_valid); end
        n_tests++; if (redirect_pc !== 32'h340) begin n_fail++; $display("FAIL wp_redirect_pc: got %0h want 340", redirect_pc); end
        tick();
        idle();
        n_tests++; if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL wp_second_pulse: got %0h want 0", redirect_valid); end
        n_tests++; if (flush !== 1'b0) begin n_fail++; $display("FAIL wp_second_flush: got %0h want 0", flush); end
        n_tests++; if (mispredict_count !== 32'd6) begin n_fail++; $display("FAIL wp_count: got %0h want 6", mispredict_count); end
        n_tests++; if (redirect_pc !== 32'h340) begin n_fail++; $display("FAIL wp_pc_hold: got %0h want 340", redirect_pc); end
        if_pc = 32'h400;
        #1;
        n_tests++; if (if_pred_taken !== 1'b0 || if_pred_target !== 32'h404) begin n_fail++; $display("FAIL wp_no_alloc: got %0h/%0h want 0/404", if_pred_taken, if_pred_target); end
        if_pc = 32'h300;
        #1;
        n_tests++; if (if_pred_taken !== 1'b1 || if_pred_target !== 32'h340) begin n_fail++; $display("FAIL wp_first_alloc: got %0h/%0h want 1/340", if_pred_taken, if_pred_target); end
    endtask

    task automatic test_alias();
        drive_branch(32'h1100, 32'h900, 1'b1, 1'b0, 32'h1104);
        tick();
        idle();
        n_tests++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h900) begin n_fail++; $display("FAIL alias_redirect: got %0h/%0h want 1/900", redirect_valid, redirect_pc); end
        tick();
        if_pc = 32'h100;
        #1;
        n_tests++; if (if_pred_taken !== 1'b0 || if_pred_target !== 32'h104) begin n_fail++; $display("FAIL alias_old_miss: got %0h/%0h want 0/104", if_pred_taken, if_pred_target); end
        if_pc = 32'h1100;
        #1;
        n_tests++; if (if_pred_taken !== 1'b1 || if_pred_target !== 32'h900) begin n_fail++; $display("FAIL alias_new_hit: got %0h/%0h want 1/900", if_pred_taken, if_pred_target); end
    endtask

    task automatic test_same_cycle();
        drive_branch(32'h1100, 32'hA00, 1'b1, 1'b1, 32'h900);
        if_pc = 32'h1100;
        #1;
        n_tests++; if (if_pred_target !== 32'h900) begin n_fail++; $display("FAIL same_cycle_old: got %0h want 900", if_pred_target); end
        tick();
        idle();
        #1;
        n_tests++; if (if_pred_target !== 32'hA00) begin n_fail++; $display("FAIL same_cycle_new: got %0h want a00", if_pred_target); end
        tick();
    endtask

    task automatic test_random();
        bit          pt;
        logic [31:0] ptg;
        for (int n = 0; n < 400; n++) begin
            rst            = ($urandom_range(0, 49) == 0);
            ex_valid       = ($urandom_range(0, 3) != 0);
            ex_is_branch   = ($urandom_range(0, 3) != 0);
            ex_pc          = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2);
            ex_target      = 32'h1000 + 32'($urandom_range(0, 3) * 16);
            ex_branch_flag = $urandom_range(0, 1);
            model_lookup(ex_pc, pt, ptg);
            if ($urandom_range(0, 3) == 0) begin
                pt  = $urandom_range(0, 1);
                ptg = pt ? ex_target : ex_pc + 32'd4;
            end
            ex_pred_taken  = pt;
            ex_pred_target = ptg;
            if_pc = $urandom_range(0, 1) ? ex_pc
                                         : (($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2));
            #1;
            model_lookup(if_pc, pt, ptg);
            n_tests++; if (if_pred_taken !== pt || if_pred_target !== ptg) begin n_fail++; $display("FAIL rnd%0d_lookup pc=%0h: got %0h/%0h want %0h/%0h", n, if_pc, if_pred_taken, if_pred_target, pt, ptg); end
            tick();
            n_tests++; if (redirect_valid !== m_rv || flush !== m_rv) begin n_fail++; $display("FAIL rnd%0d_redirect: got %0h/%0h want %0h", n, redirect_valid, flush, m_rv); end
            n_tests++; if (redirect_pc !== m_rpc) begin n_fail++; $display("FAIL rnd%0d_redirect_pc: got %0h want %0h", n, redirect_pc, m_rpc); end
            n_tests++; if (mispredict_count !== m_cnt) begin n_fail++; $display("FAIL rnd%0d_count: got %0h want %0h", n, mispredict_count, m_cnt); end
        end
        rst = 1'b0;
        idle();
        tick();
    endtask

    task automatic test_reset_mid();
        drive_branch(32'h500, 32'h540, 1'b1, 1'b0, 32'h504);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle();
        n_tests++; if (redirect_valid !== 1'b0 || flush !== 1'b0) begin n_fail++; $display("FAIL rstmid_redirect: got %0h/%0h want 0/0", redirect_valid, flush); end
        n_tests++; if (mispredict_count !== 32'd0 || redirect_pc !== 32'd0) begin n_fail++; $display("FAIL rstmid_regs: got %0h/%0h want 0/0", mispredict_count, redirect_pc); end
        for (int k = 0; k < 64; k++) begin
            if_pc = 32'(k << 2) | 32'h100;
            #1;
            n_tests++; if (if_pred_taken !== 1'b0) begin n_fail++; $display("FAIL rstmid_slot%0d: got %0h want 0", k, if_pred_taken); end
        end
    endtask

    initial begin
        rst = 1'b1;
        if_pc = 32'd0;
        idle();
        test_reset();
        test_cold_taken();
        test_correct_pred();
        test_target_mismatch();
        test_wrong_path();
        test_alias();
        test_same_cycle();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/branch_predict_resolve.md
Name: branch_predict_resolve

Overview:
- 2-bit-counter branch target buffer (BTB) plus mispredict resolver. Sits around the branch condition stage.
- In IF: combinationally predicts direction and target for the fetch PC.
- In EX: consumes the resolved branch flag, trains the table, and issues a registered one-cycle redirect/flush to the IFU on mispredict.

Parameters:
- IDX_BITS, 6, log2 of table entries (64 entries); index = pc[IDX_BITS+1:2], tag = pc[31:IDX_BITS+2]

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- if_pc  in  32  fetch PC to look up
- if_pred_taken  out  1  predicted taken (combinational)
- if_pred_target  out  32  predicted next PC (combinational)
- ex_valid  in  1  EX stage holds a valid instruction
- ex_is_branch  in  1  EX instruction is B-type
- ex_pc  in  32  PC of EX instruction
- ex_target  in  32  computed branch target (pc+imm)
- ex_branch_flag  in  1  resolved condition from branch condition unit
- ex_pred_taken  in  1  prediction carried down pipeline with this instruction
- ex_pred_target  in  32  predicted next PC carried down pipeline
- redirect_valid  out  1  registered; IFU must load redirect_pc
- redirect_pc  out  32  registered correct next PC
- flush  out  1  registered; kill IF/ID and ID/EX contents
- mispredict_count  out  32  registered count of mispredicts

Behaviour:
- Entry fields:
  - valid (1 bit)
  - tag (32-IDX_BITS-2 bits)
  - target (32 bits)
  - ctr (2 bits): 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T
- Reset (rst=1 at clk edge):
  - all valid=0, all ctr=01
  - redirect_valid=0, flush=0, redirect_pc=0, mispredict_count=0
- Lookup (combinational, no latency):
  - hit = valid[idx] & tag match.
  - if_pred_taken = hit & ctr[1].
  - if_pred_target = if_pred_taken ? target[idx] : if_pc+4 (32-bit wrap).
- Update qualifier: upd = ex_valid & ex_is_branch & ~redirect_valid. In the redirect cycle the EX instruction is wrong-path: no training, no count, no new redirect.
- Training, applied at the clk edge when upd=1, with actual = ex_branch_flag:
  - Hit on ex_pc: ctr saturating +1 if actual, else saturating -1 (11 stays 11, 00 stays 00). If actual, target <= ex_target.
  - Miss, actual=1: allocate (overwrite any occupant): valid=1, tag, target=ex_target, ctr=10.
  - Miss, actual=0: no change.
- Mispredict:
  - mp = upd & ((actual != ex_pred_taken) | (actual & ex_pred_target != ex_target)).
- Redirect, registered with one-cycle latency:
  - Cycle after mp: redirect_valid=1, flush=1, redirect_pc = actual ? ex_target : ex_pc+4.
  - Otherwise redirect_valid=0 and flush=0; redirect_pc holds its last value.
  - Pulses are exactly one cycle wide.
- mispredict_count increments by 1 on each mp and wraps at 2^32.
- Same-cycle lookup and update to the same index: lookup returns the pre-update (old) entry. The new value is visible the following cycle.
- Non-branch instructions (ex_is_branch=0) and bubbles (ex_valid=0): no table change, no redirect.
- Reset mid-operation: rst overrides a pending mp; outputs are 0 on the next cycle.
- Table storage may be flops or inferred distributed RAM. It needs an asynchronous read port and a synchronous write port.

Test Plan:
- Post-reset lookup:
  - Stimulus: rst 2 cycles, then if_pc=0x100.
  - Required: if_pred_taken=0, if_pred_target=0x104; redirect_valid=0, mispredict_count=0.
- Cold taken branch:
  - Stimulus: ex_valid=1, ex_is_branch=1, ex_pc=0x100, ex_target=0x80, flag=1, pred_taken=0, pred_target=0x104.
  - Required next cycle: redirect_valid=1, flush=1, redirect_pc=0x80, mispredict_count=1.
  - Required after: if_pc=0x100 gives pred_taken=1, target=0x80.
- Correct prediction:
  - Stimulus: repeat the 0x100 branch with pred_taken=1, pred_target=0x80, flag=1.
  - Required: no redirect, count unchanged, ctr 10->11.
  - Then three not-taken resolutions: ctr 11->10->01->00.
  - Required: if_pred_taken=0 once ctr=01. The 2nd not-taken (pred T) redirects to 0x104; the 3rd (pred NT) does not.
- Target mismatch:
  - Stimulus: entry at 0x100 with target 0x80; resolve flag=1, ex_target=0x200, pred_target=0x80.
  - Required: redirect_pc=0x200; entry target becomes 0x200.
- Wrong-path suppression:
  - Stimulus: mispredicting branch in cycle N, then another mispredicting branch presented in cycle N+1.
  - Required: redirect only in N+1, with no second pulse in N+2; mispredict_count +1 only; table unchanged by the N+1 instruction.
- Alias/reset:
  - Stimulus: taken branch at 0x1100 (same index as 0x100, different tag).
  - Required: it replaces the 0x100 entry, and 0x100 then misses.
  - Stimulus: assert rst the same cycle as a mispredict.
  - Required: redirect_valid=0 next cycle, all entries invalid.
